// File: rtl/iram_port_arbiter_if.sv
// iram_port_arbiter_if: monitor request/acknowledge bundle for the instruction-RAM arbiter.
interface iram_port_arbiter_if #(
  parameter int IWIDTH = 14
);
  logic              req;
  logic              we;
  logic [IWIDTH-1:0] adr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  modport master (output req, we, adr, wdata, input ack, rdata);
  modport slave (input req, we, adr, wdata, output ack, rdata);
endinterface

// File: rtl/iram_port_arbiter.sv
// iram_port_arbiter: shares the 1R1W instruction RAM between fetch and the monitor.
// Define IRAM_ARB_PERF_EN to get a saturating fetch-stall cycle counter on stall_cnt.
module iram_port_arbiter #(
  parameter int IWIDTH    = 14,
  parameter int FETCH_WIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run,
  input  logic [IWIDTH-1:0] fetch_adr,
  output logic              fetch_stall,
  iram_port_arbiter_if.slave mon,
  output logic [IWIDTH-1:0] ram_radr,
  input  logic [31:0]       ram_rdata,
  output logic [IWIDTH-1:0] ram_wadr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  output logic [31:0]       stall_cnt
);
  localparam int CW = FETCH_WIN > 1 ? $clog2(FETCH_WIN + 1) : 1;
  typedef enum logic [2:0] {IDLE, ACC, CAP, DONE, COOL} state_t;
  state_t            state;
  logic              l_we;
  logic [IWIDTH-1:0] l_adr;
  logic [31:0]       l_wdata;
  logic [CW-1:0]     cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      l_we      <= 1'b0;
      l_adr     <= '0;
      l_wdata   <= '0;
      cnt       <= '0;
      ram_wen   <= 1'b0;
      mon.ack   <= 1'b0;
      mon.rdata <= '0;
    end else begin
      mon.ack <= 1'b0;
      ram_wen <= 1'b0;
      case (state)
        IDLE: if (mon.req) begin
          l_we    <= mon.we;
          l_adr   <= mon.adr;
          l_wdata <= mon.wdata;
          ram_wen <= mon.we;
          state   <= ACC;
        end
        ACC: begin
          mon.ack <= l_we;
          state   <= l_we ? DONE : CAP;
        end
        CAP: begin
          mon.rdata <= ram_rdata;
          mon.ack   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          cnt   <= CW'(FETCH_WIN);
          state <= (cpu_run && FETCH_WIN > 0) ? COOL : IDLE;
        end
        COOL: begin
          cnt <= cnt - 1'b1;
          if (!cpu_run || cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // a halted CPU never loses a fetch slot; a running one loses it to reads and to same-word writes
  assign fetch_stall = cpu_run && (state == CAP || (state == ACC && (!l_we || l_adr == fetch_adr)));
  assign ram_radr    = (state == ACC && !l_we) ? l_adr : fetch_adr;
  assign ram_wadr    = l_adr;
  assign ram_wdata   = l_wdata;
`ifdef IRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (fetch_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_iram_port_arbiter.sv
// tb_iram_port_arbiter: directed plus randomized checks of iram_port_arbiter against a cycle-stamped transaction model.
module tb_iram_port_arbiter;
  localparam int IW = 14;
  localparam int FW = 4;
  logic clk = 1'b0;
  logic rst_n, cpu_run;
  logic [IW-1:0] fetch_adr;
  logic fetch_stall, ram_wen;
  logic [IW-1:0] ram_radr, ram_wadr;
  logic [31:0] ram_rdata, ram_wdata, stall_cnt;
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  iram_port_arbiter_if #(.IWIDTH(IW)) mon();
  iram_port_arbiter #(.IWIDTH(IW), .FETCH_WIN(FW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_run(cpu_run), .fetch_adr(fetch_adr), .fetch_stall(fetch_stall),
    .mon(mon), .ram_radr(ram_radr), .ram_rdata(ram_rdata), .ram_wadr(ram_wadr),
    .ram_wdata(ram_wdata), .ram_wen(ram_wen), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] init_word(input logic [IW-1:0] a);
    return ({18'h0, a} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  logic [31:0] mem [logic [IW-1:0]];
  always @(posedge clk) begin : ram
    logic [31:0] rd;
    rd = mem.exists(ram_radr) ? mem[ram_radr] : init_word(ram_radr);
    if (ram_wen) mem[ram_wadr] = ram_wdata;
    ram_rdata <= rd;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // transaction model: an access granted in cycle g has its ACC at g+1, CAP at g+2 (reads), ack at g+3 (read) or g+2 (write)
  logic [31:0] ref_mem [logic [IW-1:0]];
  bit act_m = 0, a_we;
  logic [IW-1:0] a_adr;
  logic [31:0] a_dat, m_rdata = '0;
  int g, cool = 0;
  longint m_scnt = 0;
  always @(negedge clk) begin : model
    logic e_ack, e_stall, e_wen;
    logic [IW-1:0] e_radr;
    int k;
    e_ack = 0; e_stall = 0; e_wen = 0; e_radr = fetch_adr; k = 0;
    if (rst_n === 1'b1 && act_m) begin
      k = cyc - g;
      if (!a_we) begin
        if (k == 1) e_radr = a_adr;
        e_stall = cpu_run && (k == 1 || k == 2);
        e_ack = (k == 3);
      end else begin
        e_wen = (k == 1);
        e_stall = cpu_run && k == 1 && a_adr == fetch_adr;
        e_ack = (k == 2);
      end
    end
    if (rst_n !== 1'b1) begin
      act_m = 0; cool = 0; m_rdata = '0; m_scnt = 0;
    end
    chk("mon_ack", mon.ack, e_ack);
    chk("fetch_stall", fetch_stall, e_stall);
    chk("ram_wen", ram_wen, e_wen);
    chk("ram_radr", ram_radr, e_radr);
    chk("mon_rdata", mon.rdata, m_rdata);
`ifdef IRAM_ARB_PERF_EN
    chk("stall_cnt", stall_cnt, m_scnt[31:0]);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
`endif
    if (e_wen) begin
      chk("ram_wadr", ram_wadr, a_adr);
      chk("ram_wdata", ram_wdata, a_dat);
    end
    if (rst_n === 1'b1) begin
      if (act_m && !a_we && k == 2) m_rdata = ref_mem.exists(a_adr) ? ref_mem[a_adr] : init_word(a_adr);
      if (e_wen) ref_mem[a_adr] = a_dat;
      if (e_stall) m_scnt++;
      if (e_ack) begin
        act_m = 0;
        cool = (cpu_run && FW > 0) ? FW : 0;
      end else if (!act_m && cool > 0) cool = cpu_run ? cool - 1 : 0;
      else if (!act_m && mon.req) begin
        act_m = 1; g = cyc; a_we = mon.we; a_adr = mon.adr; a_dat = mon.wdata;
      end
    end
  end
  task automatic run_req(input bit we, input logic [IW-1:0] adr, input logic [31:0] dat,
                         output int ack_off, output int n_stall, output int n_hit,
                         output int wen_stall, output int acc_cyc, output int ack_cyc);
    ack_off = -1; n_stall = 0; n_hit = 0; wen_stall = -1; acc_cyc = -1; ack_cyc = -1;
    mon.req = 1; mon.we = we; mon.adr = adr; mon.wdata = dat;
    for (int i = 0; i < 30 && ack_off < 0; i++) begin
      @(negedge clk);
      n_stall += int'(fetch_stall);
      if (!we && ram_radr == adr) begin
        n_hit++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (ram_wen) begin wen_stall = int'(fetch_stall); acc_cyc = cyc; end
      if (mon.ack) begin ack_off = i; ack_cyc = cyc; end
      @(posedge clk); #1;
    end
    mon.req = 0;
    if (ack_off < 0) chk("ack_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int ao, ns, nh, ws, ac, kc, ack1, acks;
    rst_n = 0; cpu_run = 0; fetch_adr = 14'h005;
    mon.req = 0; mon.we = 0; mon.adr = '0; mon.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", mon.ack, 0);
    chk("rst_rdata", mon.rdata, 0);
    chk("rst_wen", ram_wen, 0);
    @(posedge clk); #1 rst_n = 1;
    run_req(1, 14'h010, 32'hDEADBEEF, ao, ns, nh, ws, ac, kc);
    chk("halted_wr_ack_cycle", ao, 2);
    chk("halted_wr_stall", ns, 0);
    run_req(0, 14'h010, 32'h0, ao, ns, nh, ws, ac, kc);
    chk("halted_rd_ack_cycle", ao, 3);
    chk("halted_rd_data", mon.rdata, 32'hDEADBEEF);
    chk("halted_rd_stall", ns, 0);
    cpu_run = 1; fetch_adr = 14'h020;
    idle(2);
    run_req(0, 14'h100, 32'h0, ao, ns, nh, ws, ac, kc);
    chk("run_rd_stall_cycles", ns, 2);
    chk("run_rd_radr_cycles", nh, 1);
    chk("run_rd_data", mon.rdata, init_word(14'h100));
    idle(8);
    run_req(0, 14'h100, 32'h0, ao, ns, nh, ws, ac, ack1);
    run_req(0, 14'h101, 32'h0, ao, ns, nh, ws, ac, kc);
    chk("b2b_gap_ge5", (ac - ack1) >= 5, 1);
    chk("b2b_second_stall", ns, 2);
    fetch_adr = 14'h030;
    idle(8);
    run_req(1, 14'h030, 32'h1234_5678, ao, ns, nh, ws, ac, kc);
    chk("collide_wr_stall", ws, 1);
    idle(8);
    run_req(1, 14'h031, 32'h8765_4321, ao, ns, nh, ws, ac, kc);
    chk("nocollide_wr_stall", ws, 0);
    idle(8);
    mon.req = 1; mon.we = 0; mon.adr = 14'h010;
    idle(2);
    rst_n = 0; mon.req = 0;
    acks = 0;
    repeat (3) begin @(negedge clk); acks += int'(mon.ack); end
    chk("rst_cap_no_ack", acks, 0);
    chk("rst_cap_rdata", mon.rdata, 0);
    @(posedge clk); #1 rst_n = 1;
    run_req(0, 14'h010, 32'h0, ao, ns, nh, ws, ac, kc);
    chk("post_rst_ack_cycle", ao, 3);
    chk("post_rst_rdata", mon.rdata, 32'hDEADBEEF);
    idle(6);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    repeat (3) begin
      run_req(0, 14'h011, 32'h0, ao, ns, nh, ws, ac, kc);
      idle(1);
    end
`ifdef IRAM_ARB_PERF_EN
    chk("perf_3_reads", stall_cnt, 6);
`else
    chk("perf_3_reads", stall_cnt, 0);
`endif
    for (int i = 0; i < 4000; i++) begin
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(499) == 0) rst_n = 0;
      if ($urandom_range(9) == 0) cpu_run = ~cpu_run;
      fetch_adr = IW'($urandom_range(7)) + 14'h010;
      if (!mon.req) begin
        if ($urandom_range(2) == 0) begin
          mon.req = 1; mon.we = 1'($urandom_range(1));
          mon.adr = IW'($urandom_range(7)) + 14'h010; mon.wdata = $urandom;
        end
      end else if (mon.ack) begin
        if ($urandom_range(1) == 0) mon.req = 0;
      end else begin
        if ($urandom_range(15) == 0) mon.req = 0;
        if ($urandom_range(7) == 0) begin
          mon.we = ~mon.we; mon.adr = IW'($urandom_range(7)) + 14'h010; mon.wdata = $urandom;
        end
      end
      @(posedge clk); #1;
    end
    mon.req = 0; rst_n = 1;
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
